inst_buffer_scheduler: RTL
==========================

INST_BUFFER_SCHEDULER -- requirements
Module: inst_buffer_scheduler

Interface
REQ-001 Parameter QUEUE_DEPTH, default 32: instruction buffer entries; power of two.
REQ-002 Parameter QUEUE_LOG, default 5: log2(QUEUE_DEPTH).
REQ-003 Parameter FETCH_WIDTH, default 8: maximum instructions written per cycle.
REQ-004 Parameter DISPATCH_WIDTH, default 4: instructions read per dispatch.
REQ-005 Parameter FLUSH_HOLD, default 2: number of cycles spent in FLUSH; at least 1.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 flush_i  in  1  control mispredict; discard all buffered instructions.
REQ-009 stall_i  in  1  backend full (rename, issue queue or active list).
REQ-010 fetchValid_i  in  1  decode offers a bundle this cycle.
REQ-011 fetchVector_i  in  FETCH_WIDTH  per-slot valid bits; legal only as a contiguous run from bit 0.
REQ-012 fetchAccept_o  out  1  the bundle is written this cycle.
REQ-013 fetchStall_o  out  1  backpressure to FetchStage1 and FetchStage2.
REQ-014 writeCount_o  out  QUEUE_LOG  instructions written this cycle.
REQ-015 tailPtr_o  out  QUEUE_LOG  base write address; slot k writes tailPtr_o+k, modulo QUEUE_DEPTH.
REQ-016 headPtr_o  out  QUEUE_LOG  base read address; read port k reads headPtr_o+k.
REQ-017 dispatchFire_o  out  1  DISPATCH_WIDTH entries leave the buffer this cycle.
REQ-018 instCount_o  out  QUEUE_LOG+1  registered occupancy.
REQ-019 flushBusy_o  out  1  the scheduler is in FLUSH or RECOVER.
REQ-020 protocolErr_o  out  1  sticky flag for an illegal fetchVector_i.

Function
REQ-021 States: RUN, FLUSH and RECOVER, plus a flush hold counter of width ceil(log2(FLUSH_HOLD+1)).
REQ-022 In any state, flush_i=1 moves the next state to FLUSH and loads the hold counter with FLUSH_HOLD-1.
REQ-023 In FLUSH, the hold counter decrements each cycle; when it reaches 0, the next state is RECOVER.
REQ-024 RECOVER lasts exactly 1 cycle and then moves to RUN.
REQ-025 A new flush_i while in FLUSH or RECOVER restarts FLUSH from a full hold count.
REQ-026 The cycle after flush_i is asserted, headPtr, tailPtr and instCount are all 0.
REQ-027 fetchStall_o = (state != RUN) | (instCount_o > QUEUE_DEPTH - FETCH_WIDTH); this is combinational from registered state only.
REQ-028 fetchAccept_o = fetchValid_i & ~fetchStall_o & ~flush_i.
REQ-029 writeCount_o = popcount(fetchVector_i) when fetchAccept_o is 1, otherwise 0.
REQ-030 dispatchFire_o = (state == RUN) & ~stall_i & ~flush_i & (instCount_o >= DISPATCH_WIDTH).
REQ-031 Next tailPtr = tailPtr + writeCount_o, wrapping modulo QUEUE_DEPTH.
REQ-032 Next headPtr = headPtr + DISPATCH_WIDTH when dispatchFire_o is 1, wrapping modulo QUEUE_DEPTH.
REQ-033 Next instCount = instCount + writeCount_o - (dispatchFire_o ? DISPATCH_WIDTH : 0).
REQ-034 Simultaneous write and dispatch in the same cycle are both applied.
REQ-035 instCount never exceeds QUEUE_DEPTH and never underflows, by construction of REQ-027 and REQ-030.
REQ-036 The invariant (tailPtr - headPtr) mod QUEUE_DEPTH == instCount mod QUEUE_DEPTH holds in every cycle.
REQ-037 protocolErr_o sets when fetchAccept_o=1 and fetchVector_i is non-contiguous (any 1 above a 0) or all-zero.
REQ-038 protocolErr_o is cleared only by reset; flush_i does not clear it.
REQ-039 An illegal bundle is still written with its popcount.

Reset
REQ-040 While reset=1: state=RUN, headPtr=0, tailPtr=0, instCount=0, hold counter=0, protocolErr_o=0.
REQ-041 While reset=1, all outputs are forced to 0 except fetchStall_o, which is 1.
REQ-042 reset has priority over flush_i.
REQ-043 reset asserted mid-FLUSH returns the block to RUN on the next cycle.

Verification
REQ-044 Fill: from reset, accept 8'hFF for 4 cycles with stall_i=1. Required: instCount 8, 16, 24, 32; fetchStall_o=1 once count is 32; the 5th bundle is not accepted.
REQ-045 Steady state: count=8, fetchVector_i=8'h0F every cycle, stall_i=0. Required: dispatchFire_o=1 every cycle; count stays at 8; both pointers advance by 4 each cycle.
REQ-046 Wrap: head=28, tail=30, count=2, write 8'h3F. Required: tail becomes 4 and count becomes 8; no dispatch that cycle.
REQ-047 Flush: flush_i pulsed at count=20. Required: the next cycle has count=0 and pointers=0; flushBusy_o=1 for FLUSH_HOLD+1 cycles (3 with the default); the first accept is possible on the 4th cycle after the flush.
REQ-048 Re-flush: flush_i asserted again in the 2nd FLUSH cycle. Required: the FLUSH hold restarts and flushBusy_o is extended.
REQ-049 Protocol: accept 8'h05. Required: protocolErr_o=1 from the next cycle, writeCount_o=2, and the flag persists through a later flush_i.

Source files
------------

// File: rtl/inst_buffer_scheduler_if.sv
// Fetch-to-dispatch handshake bundle for the instruction buffer scheduler.
// The scheduler drives the _o signals (slave side). Decode, the backend and
// recovery drive the _i signals (master side).
interface inst_buffer_scheduler_if #(
    parameter int QUEUE_LOG   = 5,
    parameter int FETCH_WIDTH = 8
);
    logic                   flush_i;
    logic                   stall_i;
    logic                   fetchValid_i;
    logic [FETCH_WIDTH-1:0] fetchVector_i;
    logic                   fetchAccept_o;
    logic                   fetchStall_o;
    logic [QUEUE_LOG-1:0]   writeCount_o;
    logic [QUEUE_LOG-1:0]   tailPtr_o;
    logic [QUEUE_LOG-1:0]   headPtr_o;
    logic                   dispatchFire_o;
    logic [QUEUE_LOG:0]     instCount_o;
    logic                   flushBusy_o;
    logic                   protocolErr_o;

    modport master (
        output flush_i, stall_i, fetchValid_i, fetchVector_i,
        input  fetchAccept_o, fetchStall_o, writeCount_o, tailPtr_o, headPtr_o,
               dispatchFire_o, instCount_o, flushBusy_o, protocolErr_o
    );

    modport slave (
        input  flush_i, stall_i, fetchValid_i, fetchVector_i,
        output fetchAccept_o, fetchStall_o, writeCount_o, tailPtr_o, headPtr_o,
               dispatchFire_o, instCount_o, flushBusy_o, protocolErr_o
    );
endinterface

// File: rtl/inst_buffer_scheduler.sv
// Instruction buffer scheduler: owns the head/tail pointers and occupancy of a
// circular instruction buffer, accepts variable-width fetch bundles, releases
// fixed-width dispatch groups and sequences mispredict recovery
// (RUN -> FLUSH for FLUSH_HOLD cycles -> RECOVER for one cycle -> RUN).
module inst_buffer_scheduler #(
    parameter int QUEUE_DEPTH    = 32,
    parameter int QUEUE_LOG      = 5,
    parameter int FETCH_WIDTH    = 8,
    parameter int DISPATCH_WIDTH = 4,
    parameter int FLUSH_HOLD     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    inst_buffer_scheduler_if.slave sched
);

    localparam int HOLD_W = (FLUSH_HOLD < 1) ? 1 : $clog2(FLUSH_HOLD + 1);

    localparam logic [HOLD_W-1:0]    HOLD_LOAD     = HOLD_W'(FLUSH_HOLD - 1);
    localparam logic [HOLD_W-1:0]    HOLD_ONE      = HOLD_W'(1);
    // A bundle is refused once fewer than FETCH_WIDTH free entries could remain.
    localparam logic [QUEUE_LOG:0]   STALL_LEVEL   = (QUEUE_LOG+1)'(QUEUE_DEPTH - FETCH_WIDTH);
    localparam logic [QUEUE_LOG:0]   DISPATCH_CNT  = (QUEUE_LOG+1)'(DISPATCH_WIDTH);
    localparam logic [QUEUE_LOG-1:0] DISPATCH_STEP = QUEUE_LOG'(DISPATCH_WIDTH);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } schedState_t;

    // Number of valid slots in a fetch bundle.
    function automatic logic [QUEUE_LOG:0] popCount(input logic [FETCH_WIDTH-1:0] vec);
        logic [QUEUE_LOG:0] cnt;
        cnt = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            cnt = cnt + (QUEUE_LOG+1)'(vec[k]);
        end
        return cnt;
    endfunction

    // Legal bundles are a non-empty run of ones starting at slot 0: adding one
    // to such a vector clears every set bit, so the AND with it is zero.
    function automatic logic vectorLegal(input logic [FETCH_WIDTH-1:0] vec);
        logic [FETCH_WIDTH-1:0] vecInc;
        vecInc = vec + FETCH_WIDTH'(1);
        return (vec != '0) && ((vec & vecInc) == '0);
    endfunction

    schedState_t          state, stateNext;
    logic [HOLD_W-1:0]    holdCnt, holdCntNext;
    logic [QUEUE_LOG-1:0] headPtr, headPtrNext;
    logic [QUEUE_LOG-1:0] tailPtr, tailPtrNext;
    logic [QUEUE_LOG:0]   instCount, instCountNext;
    logic                 protocolErr, protocolErrNext;

    logic                 inRun;
    logic                 fetchStall;
    logic                 fetchAccept;
    logic                 dispatchFire;
    logic [QUEUE_LOG:0]   fetchPop;
    logic [QUEUE_LOG:0]   writeCnt;
    logic                 bundleLegal;

    // Handshake decisions, derived from registered state plus this cycle's requests.
    always_comb begin
        inRun        = (state == RUN);
        fetchStall   = reset | ~inRun | (instCount > STALL_LEVEL);
        fetchAccept  = sched.fetchValid_i & ~fetchStall & ~sched.flush_i;
        fetchPop     = popCount(sched.fetchVector_i);
        bundleLegal  = vectorLegal(sched.fetchVector_i);
        writeCnt     = fetchAccept ? fetchPop : '0;
        dispatchFire = ~reset & inRun & ~sched.stall_i & ~sched.flush_i
                       & (instCount >= DISPATCH_CNT);
    end

    // Recovery sequencing: a flush always (re)starts a full hold, whatever the state.
    always_comb begin
        stateNext   = state;
        holdCntNext = holdCnt;
        if (sched.flush_i) begin
            stateNext   = FLUSH;
            holdCntNext = HOLD_LOAD;
        end else begin
            case (state)
                RUN: begin
                    stateNext = RUN;
                end
                FLUSH: begin
                    if (holdCnt == '0) begin
                        stateNext = RECOVER;
                    end else begin
                        holdCntNext = holdCnt - HOLD_ONE;
                    end
                end
                RECOVER: begin
                    stateNext = RUN;
                end
                default: begin
                    stateNext   = RUN;
                    holdCntNext = '0;
                end
            endcase
        end
    end

    // Pointer and occupancy update; write and dispatch in the same cycle both apply.
    always_comb begin
        headPtrNext     = headPtr;
        tailPtrNext     = tailPtr;
        instCountNext   = instCount;
        protocolErrNext = protocolErr | (fetchAccept & ~bundleLegal);
        if (sched.flush_i) begin
            headPtrNext   = '0;
            tailPtrNext   = '0;
            instCountNext = '0;
        end else begin
            headPtrNext   = headPtr + (dispatchFire ? DISPATCH_STEP : '0);
            tailPtrNext   = tailPtr + writeCnt[QUEUE_LOG-1:0];
            instCountNext = instCount + writeCnt - (dispatchFire ? DISPATCH_CNT : '0);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            holdCnt <= '0;
        end else begin
            state   <= stateNext;
            holdCnt <= holdCntNext;
        end
    end

    // Buffer bookkeeping registers; the protocol flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr     <= '0;
            tailPtr     <= '0;
            instCount   <= '0;
            protocolErr <= 1'b0;
        end else begin
            headPtr     <= headPtrNext;
            tailPtr     <= tailPtrNext;
            instCount   <= instCountNext;
            protocolErr <= protocolErrNext;
        end
    end

    // Outputs are held quiet while reset is asserted, with fetch backpressure raised.
    assign sched.fetchAccept_o  = fetchAccept;
    assign sched.fetchStall_o   = fetchStall;
    assign sched.writeCount_o   = writeCnt[QUEUE_LOG-1:0];
    assign sched.tailPtr_o      = reset ? '0 : tailPtr;
    assign sched.headPtr_o      = reset ? '0 : headPtr;
    assign sched.dispatchFire_o = dispatchFire;
    assign sched.instCount_o    = reset ? '0 : instCount;
    assign sched.flushBusy_o    = ~reset & ~inRun;
    assign sched.protocolErr_o  = ~reset & protocolErr;

endmodule
